instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front end of the MiniProcessor: owns the program counter, drives the instruction memory address, and registers the returned 28-bit instruction. It splits the instruction into operation, destination and source fields for the execute stage. The block issues addresses to the combinational program ROM and consumes its instruction word. The execute stage feeds back stall and branch/jump redirects. A taken redirect costs one bubble.

## Interface
- ADDR_W, 16, program counter / instruction address width
- INSTR_W, 28, instruction width: {operation[27:24], destination[23:16], source1[15:8], source0[7:0]}
- RESET_ADDR, 0, first fetch address after reset
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- iStall  in  1  execute stage not ready; hold all fetch state
- iBranchTaken  in  1  redirect request for the instruction currently in oOperation/oPC (BLE taken, JMP)
- iBranchTarget  in  ADDR_W  redirect address (for example the 8-bit LOOP label zero-extended)
- oAddress  out  ADDR_W  address to program ROM (= PC register)
- iInstruction  in  INSTR_W  ROM data for oAddress, valid in the same cycle
- oValid  out  1  oOperation and fields hold a real instruction
- oOperation  out  4  instruction[27:24]
- oDestination  out  8  instruction[23:16]
- oSourceAddr1  out  8  instruction[15:8]
- oSourceAddr0  out  8  instruction[7:0]
- oImmediate  out  16  instruction[15:0] (STO literal)
- oPC  out  ADDR_W  address the registered instruction was fetched from
- oFetchCount  out  16  number of valid instructions delivered, wraps

## Operation
- State: PC, instruction register (IR), oPC, valid flag, and fetch counter. A valid flag is used, so no FSM encoding is needed. The equivalent modes are:
  - RUN: oValid=1
  - BUBBLE: oValid=0 after reset or redirect
  - HOLD: iStall=1
- Reset (highest priority, even mid-stall or mid-branch):
  - PC=RESET_ADDR
  - IR=0, so all field outputs are 0
  - oPC=0, oValid=0, oFetchCount=0
- Each edge is handled by the first matching case:
  - Reset: as above.
  - iBranchTaken=1: PC←iBranchTarget and oValid←0, so the instruction fetched from PC is discarded. IR and oPC hold. The counter does not increment. The branch overrides iStall.
  - iStall=1: PC, IR, oPC, oValid and the counter all hold. The ROM address stays stable.
  - Otherwise: IR←iInstruction, oPC←PC, oValid←1, PC←PC+1, oFetchCount←oFetchCount+1.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 wraps to 0. oFetchCount 16'hFFFF wraps to 0.
- iBranchTaken is accepted whether or not oValid=1. The execute stage gates it with oValid.
- iBranchTarget is sampled only on the edge where iBranchTaken=1.
- Field outputs are pure slices of IR, with no decode. Unused fields (for example in a LED instruction) pass through unchanged.

## Timing
- Cycle 0 after Reset release:
  - oAddress=RESET_ADDR, oValid=0.
  - At the end of cycle 0, IR captures ROM[RESET_ADDR].
  - Cycle 1: oValid=1, oPC=RESET_ADDR, oAddress=RESET_ADDR+1.
- Throughput: one instruction per clock when iStall=0.
- Redirect asserted in cycle n with target T:
  - Cycle n+1: oAddress=T, oValid=0.
  - Cycle n+2: oOperation=ROM[T] fields, oPC=T, oValid=1.
  - Penalty is one bubble.
- Stall in cycle n: outputs in cycle n+1 equal those in cycle n.
- Stall and branch in the same cycle: the branch is taken, as above.
- Reset asserted during any cycle: the outputs show reset values in the next cycle.
- oAddress is registered. The ROM is combinational, so the address-to-IR path is a single cycle.

## Test plan
- Reset then free run with ROM words 0..3:
  - Cycle 1: oPC=0, oValid=1, oOperation=ROM[0][27:24].
  - Cycle 4: oPC=3, oFetchCount=4, oAddress=4.
- Redirect: with oPC=10, pulse iBranchTaken and iBranchTarget=9.
  - Next cycle: oValid=0, oAddress=9, oFetchCount unchanged.
  - Following cycle: oPC=9, oValid=1.
- Stall for 3 cycles with oPC=5: oPC, oAddress=6, oValid and all fields are frozen. Releasing the stall resumes at oPC=6.
- Branch and stall in the same cycle with target 3: after 2 cycles oPC=3 and oValid=1, and the stall is ignored for that edge.
- Wrap: force PC to 16'hFFFF via a branch. The next deliveries have oPC=16'hFFFF then oPC=0. The counter 16'hFFFF wraps to 0.
- Reset mid-run (oPC=12, iStall=1, iBranchTaken=1): the next cycle shows oValid=0, oAddress=0, oPC=0, oFetchCount=0 and all fields 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch front end: PC drives the combinational ROM, IR registers the returned word (1 cycle).
// Stall freezes all fetch state; a taken redirect overrides stall and inserts one bubble.
module instruction_fetch #(
  parameter int unsigned              ADDR_W     = 16,
  parameter int unsigned              INSTR_W    = 28,
  parameter logic [ADDR_W-1:0]        RESET_ADDR = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic               oValid,
  output logic [3:0]         oOperation,
  output logic [7:0]         oDestination,
  output logic [7:0]         oSourceAddr1,
  output logic [7:0]         oSourceAddr0,
  output logic [15:0]        oImmediate,
  output logic [ADDR_W-1:0]  oPC,
  output logic [15:0]        oFetchCount
);

  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_valid;
  logic [15:0]        fetch_count;

  // Redirect wins over stall so a taken branch is never lost while execute is busy.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc          <= RESET_ADDR;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (iBranchTaken) begin
      pc       <= iBranchTarget;
      ir_valid <= 1'b0;
    end else if (!iStall) begin
      ir          <= iInstruction;
      ir_pc       <= pc;
      ir_valid    <= 1'b1;
      pc          <= pc + 1'b1;
      fetch_count <= fetch_count + 16'd1;
    end
  end

  assign oAddress     = pc;
  assign oValid       = ir_valid;
  assign oPC          = ir_pc;
  assign oFetchCount  = fetch_count;

  // Fields are raw slices; decoding belongs to execute.
  assign oOperation   = ir[27:24];
  assign oDestination = ir[23:16];
  assign oSourceAddr1 = ir[15:8];
  assign oSourceAddr0 = ir[7:0];
  assign oImmediate   = ir[15:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a combinational ROM model.
module tb_instruction_fetch;

  logic        Clock;
  logic        Reset;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        oValid;
  logic [3:0]  oOperation;
  logic [7:0]  oDestination;
  logic [7:0]  oSourceAddr1;
  logic [7:0]  oSourceAddr0;
  logic [15:0] oImmediate;
  logic [15:0] oPC;
  logic [15:0] oFetchCount;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt;

  instruction_fetch #(.ADDR_W(16), .INSTR_W(28), .RESET_ADDR(16'h0000)) dut (
    .Clock(Clock), .Reset(Reset), .iStall(iStall), .iBranchTaken(iBranchTaken),
    .iBranchTarget(iBranchTarget), .oAddress(oAddress), .iInstruction(iInstruction),
    .oValid(oValid), .oOperation(oOperation), .oDestination(oDestination),
    .oSourceAddr1(oSourceAddr1), .oSourceAddr0(oSourceAddr0), .oImmediate(oImmediate),
    .oPC(oPC), .oFetchCount(oFetchCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [27:0] rom_word(input logic [15:0] a);
    logic [7:0] d;
    d = a[7:0] + 8'h30;
    return {a[3:0] ^ 4'hA, d, a[15:8] ^ a[7:0], ~a[7:0]};
  endfunction

  always_comb iInstruction = rom_word(oAddress);

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [27:0] w;
    Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 16'h0;
    step();
    step();
    Reset = 1'b0;
    exp_cnt = 16'd0;
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", oValid); end
    checks++; if (oAddress !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", oAddress); end
    checks++; if (oPC !== 16'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", oPC); end
    checks++; if (oFetchCount !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0000", oFetchCount); end
    checks++; if ({oOperation, oDestination, oSourceAddr1, oSourceAddr0} !== 28'h0) begin
      errors++; $display("FAIL reset_fields got %h want 0", {oOperation, oDestination, oSourceAddr1, oSourceAddr0}); end
    step(); exp_cnt++;
    w = rom_word(16'd0);
    checks++; if (oPC !== 16'd0 || oValid !== 1'b1) begin
      errors++; $display("FAIL run_c1 got pc=%h v=%0b want pc=0000 v=1", oPC, oValid); end
    checks++; if (oOperation !== w[27:24] || oAddress !== 16'd1) begin
      errors++; $display("FAIL run_c1_op got op=%h a=%h want op=%h a=0001", oOperation, oAddress, w[27:24]); end
    step(); step(); step(); exp_cnt += 3;
    checks++; if (oPC !== 16'd3 || oFetchCount !== 16'd4 || oAddress !== 16'd4) begin
      errors++; $display("FAIL run_c4 got pc=%h cnt=%h a=%h want 0003 0004 0004", oPC, oFetchCount, oAddress); end
  endtask

  task automatic test_redirect();
    logic [27:0] w;
    for (int i = 0; i < 7; i++) step();
    exp_cnt += 7;
    checks++; if (oPC !== 16'd10) begin errors++; $display("FAIL redir_setup got pc=%h want 000a", oPC); end
    iBranchTaken = 1'b1; iBranchTarget = 16'd9;
    step();
    iBranchTaken = 1'b0; iBranchTarget = 16'hBEEF;
    checks++; if (oValid !== 1'b0 || oAddress !== 16'd9 || oFetchCount !== exp_cnt || oPC !== 16'd10) begin
      errors++; $display("FAIL redir_bubble got v=%0b a=%h cnt=%h pc=%h want 0 0009 %h 000a",
                         oValid, oAddress, oFetchCount, oPC, exp_cnt); end
    step(); exp_cnt++;
    w = rom_word(16'd9);
    checks++; if (oPC !== 16'd9 || oValid !== 1'b1 || oOperation !== w[27:24] || oAddress !== 16'd10) begin
      errors++; $display("FAIL redir_land got pc=%h v=%0b op=%h a=%h want 0009 1 %h 000a",
                         oPC, oValid, oOperation, oAddress, w[27:24]); end
    checks++; if (oFetchCount !== 16'd12) begin errors++; $display("FAIL redir_cnt got %h want 000c", oFetchCount); end
  endtask

  task automatic test_stall();
    logic [27:0] w;
    iBranchTaken = 1'b1; iBranchTarget = 16'd5;
    step();
    iBranchTaken = 1'b0;
    step(); exp_cnt++;
    w = rom_word(16'd5);
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (oPC !== 16'd5 || oAddress !== 16'd6 || oValid !== 1'b1 || oFetchCount !== exp_cnt ||
          {oOperation, oDestination, oSourceAddr1, oSourceAddr0} !== w || oImmediate !== w[15:0]) begin
        errors++; $display("FAIL stall_hold%0d got pc=%h a=%h v=%0b cnt=%h ir=%h want 0005 0006 1 %h %h",
                           i, oPC, oAddress, oValid, oFetchCount,
                           {oOperation, oDestination, oSourceAddr1, oSourceAddr0}, exp_cnt, w);
      end
    end
    iStall = 1'b0;
    step(); exp_cnt++;
    w = rom_word(16'd6);
    checks++; if (oPC !== 16'd6 || oValid !== 1'b1 || oDestination !== w[23:16] || oFetchCount !== 16'd14) begin
      errors++; $display("FAIL stall_release got pc=%h v=%0b d=%h cnt=%h want 0006 1 %h 000e",
                         oPC, oValid, oDestination, oFetchCount, w[23:16]); end
  endtask

  task automatic test_branch_stall();
    logic [27:0] w;
    iStall = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 16'd3;
    step();
    iStall = 1'b0; iBranchTaken = 1'b0;
    checks++; if (oValid !== 1'b0 || oAddress !== 16'd3) begin
      errors++; $display("FAIL brstall_bubble got v=%0b a=%h want 0 0003", oValid, oAddress); end
    step(); exp_cnt++;
    w = rom_word(16'd3);
    checks++; if (oPC !== 16'd3 || oValid !== 1'b1 || oSourceAddr1 !== w[15:8] || oSourceAddr0 !== w[7:0]) begin
      errors++; $display("FAIL brstall_land got pc=%h v=%0b s1=%h s0=%h want 0003 1 %h %h",
                         oPC, oValid, oSourceAddr1, oSourceAddr0, w[15:8], w[7:0]); end
  endtask

  task automatic test_wrap();
    iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
    step();
    iBranchTaken = 1'b0;
    step(); exp_cnt++;
    checks++; if (oPC !== 16'hFFFF || oAddress !== 16'h0000) begin
      errors++; $display("FAIL wrap_pc_hi got pc=%h a=%h want ffff 0000", oPC, oAddress); end
    step(); exp_cnt++;
    checks++; if (oPC !== 16'h0000 || oAddress !== 16'h0001 || oFetchCount !== 16'd17) begin
      errors++; $display("FAIL wrap_pc_lo got pc=%h a=%h cnt=%h want 0000 0001 0011", oPC, oAddress, oFetchCount); end
    while (exp_cnt != 16'hFFFF) begin
      step(); exp_cnt++;
    end
    checks++; if (oFetchCount !== 16'hFFFF) begin errors++; $display("FAIL cnt_max got %h want ffff", oFetchCount); end
    step(); exp_cnt++;
    checks++; if (oFetchCount !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got %h want 0000", oFetchCount); end
  endtask

  task automatic test_reset_midrun();
    iBranchTaken = 1'b1; iBranchTarget = 16'd12;
    step();
    iBranchTaken = 1'b0;
    step();
    checks++; if (oPC !== 16'd12 || oValid !== 1'b1) begin
      errors++; $display("FAIL midrst_setup got pc=%h v=%0b want 000c 1", oPC, oValid); end
    Reset = 1'b1; iStall = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 16'd7;
    step();
    Reset = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oAddress !== 16'h0 || oPC !== 16'h0 || oFetchCount !== 16'h0 ||
        oOperation !== 4'h0 || oDestination !== 8'h0 || oSourceAddr1 !== 8'h0 ||
        oSourceAddr0 !== 8'h0 || oImmediate !== 16'h0) begin
      errors++; $display("FAIL midrst got v=%0b a=%h pc=%h cnt=%h op=%h d=%h imm=%h want all zero",
                         oValid, oAddress, oPC, oFetchCount, oOperation, oDestination, oImmediate);
    end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_stall();
    test_branch_stall();
    test_wrap();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
